regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (s0) and LSU (s1).
// Registered write port; per-register busy scoreboard with write-cycle bypass on queries.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s0_valid,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              q1_busy,
  output logic              q2_busy
);

  logic                last_grant_q, last_grant_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic grant0, grant1, xfer0, xfer1;

  // On contention the source that did not win last time is granted.
  assign grant0 = s0_valid & (~s1_valid | last_grant_q);
  assign grant1 = s1_valid & (~s0_valid | ~last_grant_q);

  assign s0_ready = grant0 & ~flush & ~rst;
  assign s1_ready = grant1 & ~flush & ~rst;
  assign xfer0    = s0_valid & s0_ready;
  assign xfer1    = s1_valid & s1_ready;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (xfer0) begin
      last_grant_d = 1'b0;
      rf_waddr_d   = s0_addr;
      rf_wdata_d   = s0_data;
      rf_we_d      = (s0_addr != '0);
    end else if (xfer1) begin
      last_grant_d = 1'b1;
      rf_waddr_d   = s1_addr;
      rf_wdata_d   = s1_data;
      rf_we_d      = (s1_addr != '0);
    end
  end

  // Set is applied after clear so a newly issued producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
    if (set_en && set_addr != '0) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      busy_q       <= '0;
    end else if (flush) begin
      rf_we_q      <= 1'b0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // The register file forwards its write data, so the register being written reads as ready.
  assign q1_busy = (q1_addr != '0) & busy_q[q1_addr] & ~(rf_we_q & (rf_waddr_q == q1_addr));
  assign q2_busy = (q2_addr != '0) & busy_q[q2_addr] & ~(rf_we_q & (rf_waddr_q == q2_addr));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin order, x0 discard,
// scoreboard set/clear/bypass/collision, flush and mid-stream reset.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [4:0]  s0_addr, s1_addr, rf_waddr, set_addr, q1_addr, q2_addr;
  logic [31:0] s0_data, s1_data, rf_wdata;
  logic        rf_we, set_en, q1_busy, q2_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .set_en(set_en), .set_addr(set_addr),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h5555;
    s1_valid = 1'b0; s1_addr = '0;   s1_data = '0;
    set_en = 1'b0; set_addr = '0; q1_addr = '0; q2_addr = '0;
    step(); step();
    chk("rst_s0_ready", 32'(s0_ready), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_q1_busy", 32'(q1_busy), 32'd0);

    // single s0 write
    rst = 1'b0; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
    #1;
    chk("w5_s0_ready", 32'(s0_ready), 32'd1);
    chk("w5_s1_ready", 32'(s1_ready), 32'd0);
    step();
    s0_valid = 1'b0;
    chk("w5_rf_we", 32'(rf_we), 32'd1);
    chk("w5_rf_waddr", 32'(rf_waddr), 32'd5);
    chk("w5_rf_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    chk("w5_rf_we_drop", 32'(rf_we), 32'd0);
    chk("w5_waddr_hold", 32'(rf_waddr), 32'd5);

    // write to x0 from s1: accepted, discarded
    s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h1234;
    #1;
    chk("x0_s1_ready", 32'(s1_ready), 32'd1);
    step();
    s1_valid = 1'b0;
    chk("x0_rf_we", 32'(rf_we), 32'd0);
    chk("x0_rf_wdata", rf_wdata, 32'h1234);

    // contention: s1 was granted last, so s0 first then alternate
    s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 32'h11;
    s1_valid = 1'b1; s1_addr = 5'd2; s1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_s0_ready", 32'(s0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_s1_ready", 32'(s1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("rr_rf_we", 32'(rf_we), 32'd1);
      chk("rr_rf_waddr", 32'(rf_waddr), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    step();
    chk("rr_idle_we", 32'(rf_we), 32'd0);

    // scoreboard set, bypass, clear
    set_en = 1'b1; set_addr = 5'd7; q1_addr = 5'd7; q2_addr = 5'd0;
    #1;
    chk("sb7_before", 32'(q1_busy), 32'd0);
    step();
    set_en = 1'b0;
    chk("sb7_busy", 32'(q1_busy), 32'd1);
    chk("sb_q0_zero", 32'(q2_busy), 32'd0);
    s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'h77;
    #1;
    chk("sb7_s0_ready", 32'(s0_ready), 32'd1);
    step();
    s0_valid = 1'b0;
    chk("sb7_rf_we", 32'(rf_we), 32'd1);
    chk("sb7_bypass", 32'(q1_busy), 32'd0);
    step();
    chk("sb7_cleared", 32'(q1_busy), 32'd0);

    // set/clear collision on x9
    set_en = 1'b1; set_addr = 5'd9; q1_addr = 5'd9;
    step();
    set_en = 1'b0;
    s1_valid = 1'b1; s1_addr = 5'd9; s1_data = 32'h99;
    step();
    s1_valid = 1'b0;
    set_en = 1'b1; set_addr = 5'd9;
    chk("col_rf_waddr", 32'(rf_waddr), 32'd9);
    chk("col_bypass", 32'(q1_busy), 32'd0);
    step();
    set_en = 1'b0;
    chk("col_set_wins", 32'(q1_busy), 32'd1);

    // flush with busy 3 and 4
    set_en = 1'b1; set_addr = 5'd3; step();
    set_addr = 5'd4; step();
    set_en = 1'b0; q1_addr = 5'd3; q2_addr = 5'd4;
    #1;
    chk("fl_pre_q1", 32'(q1_busy), 32'd1);
    chk("fl_pre_q2", 32'(q2_busy), 32'd1);
    flush = 1'b1; s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h33;
    set_en = 1'b1; set_addr = 5'd5;
    #1;
    chk("fl_s0_ready", 32'(s0_ready), 32'd0);
    step();
    flush = 1'b0; s0_valid = 1'b0; set_en = 1'b0;
    #1;
    chk("fl_rf_we", 32'(rf_we), 32'd0);
    chk("fl_waddr_hold", 32'(rf_waddr), 32'd9);
    chk("fl_q1", 32'(q1_busy), 32'd0);
    chk("fl_q2", 32'(q2_busy), 32'd0);
    q1_addr = 5'd5;
    #1;
    chk("fl_set_ignored", 32'(q1_busy), 32'd0);

    // reset mid-stream
    s0_valid = 1'b1; s0_addr = 5'd10; s0_data = 32'hA;
    set_en = 1'b1; set_addr = 5'd11; q1_addr = 5'd11;
    step();
    set_en = 1'b0;
    chk("mr_rf_we", 32'(rf_we), 32'd1);
    chk("mr_busy11", 32'(q1_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_s0_ready_rst", 32'(s0_ready), 32'd0);
    step();
    chk("mr_rf_we_killed", 32'(rf_we), 32'd0);
    chk("mr_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("mr_rf_wdata", rf_wdata, 32'd0);
    chk("mr_busy_lost", 32'(q1_busy), 32'd0);
    rst = 1'b0; s1_valid = 1'b1; s1_addr = 5'd2;
    #1;
    chk("mr_lastgrant_s0", 32'(s0_ready), 32'd1);
    chk("mr_lastgrant_s1", 32'(s1_ready), 32'd0);
    s0_valid = 1'b0; s1_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
